// File: rtl/regfile_pkg.sv
// Shared defaults and the address-width derivation for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    function automatic int calc_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regfile_sb_pend.sv
// Pending-bit scoreboard: per-register pending bits and outstanding-producer counter.
module regfile_sb_pend
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int AW = calc_aw(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [NREGS-1:0] ep,
    output logic [AW:0]      busy_cnt
);

    localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

    logic [NREGS-1:0] pend_r;
    logic [NREGS-1:0] set_vec_s;
    logic [NREGS-1:0] clr_vec_s;
    logic [NREGS-1:0] pend_nxt_s;
    logic [AW:0]      busy_nxt_s;
    logic             inc_s;
    logic             dec_s;

    // Set/clear decode; an accepted set on a register being cleared nets to zero count change.
    always_comb begin
        set_vec_s  = {NREGS{1'b0}};
        clr_vec_s  = {NREGS{1'b0}};
        inc_s      = 1'b0;
        dec_s      = 1'b0;
        pend_nxt_s = {NREGS{1'b0}};
        busy_nxt_s = {(AW+1){1'b0}};
        if (set_en && !flush && (set_addr != {AW{1'b0}})) begin
            set_vec_s = ONE_HOT0 << set_addr;
            inc_s     = 1'b1;
        end else begin
            set_vec_s = {NREGS{1'b0}};
            inc_s     = 1'b0;
        end
        if (clr_en && (clr_addr != {AW{1'b0}})) begin
            clr_vec_s = ONE_HOT0 << clr_addr;
            dec_s     = pend_r[clr_addr];
        end else begin
            clr_vec_s = {NREGS{1'b0}};
            dec_s     = 1'b0;
        end
        ep = pend_r & ~clr_vec_s;
        if (flush) begin
            pend_nxt_s = {NREGS{1'b0}};
            busy_nxt_s = {(AW+1){1'b0}};
        end else begin
            pend_nxt_s = ep | set_vec_s;
            busy_nxt_s = busy_cnt + {{AW{1'b0}}, inc_s} - {{AW{1'b0}}, dec_s};
        end
    end

    // Pending state and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_r   <= {NREGS{1'b0}};
            busy_cnt <= {(AW+1){1'b0}};
        end else begin
            pend_r   <= pend_nxt_s;
            busy_cnt <= busy_nxt_s;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with writeback bypass and RAW/WAW hazard detection against the pending scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    localparam int AW = calc_aw(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_use,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_pend,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              stall,
    output logic [AW:0]       busy_cnt
);

    logic [XLEN-1:0]  mem_r [NREGS];
    logic [NREGS-1:0] ep_s;
    logic             wb_we_s;
    logic             iss_ok_s;
    logic [AW-1:0]    ra_s;

    assign wb_we_s  = wb_en && (wb_addr != {AW{1'b0}});
    assign iss_ok_s = iss_en && !stall;

    regfile_sb_pend #(
        .NREGS(NREGS)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .set_en   (iss_ok_s),
        .set_addr (iss_addr),
        .clr_en   (wb_en),
        .clr_addr (wb_addr),
        .ep       (ep_s),
        .busy_cnt (busy_cnt)
    );

    // Data array; r0 is never written so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_we_s) begin
            mem_r[wb_addr] <= wb_data;
        end else begin
            mem_r[wb_addr] <= mem_r[wb_addr];
        end
    end

    // Read ports: r0 forced to zero, same-cycle writeback bypassed over the array.
    always_comb begin
        rd_data = {(NRD*XLEN){1'b0}};
        rd_pend = {NRD{1'b0}};
        ra_s    = {AW{1'b0}};
        for (int k = 0; k < NRD; k++) begin
            ra_s = rd_addr[k*AW +: AW];
            if (ra_s == {AW{1'b0}}) begin
                rd_data[k*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if (wb_we_s && (wb_addr == ra_s)) begin
                rd_data[k*XLEN +: XLEN] = wb_data;
            end else begin
                rd_data[k*XLEN +: XLEN] = mem_r[ra_s];
            end
            rd_pend[k] = ep_s[ra_s];
        end
    end

    // RAW on any consumed operand, or WAW on the issuing destination.
    always_comb begin
        stall = 1'b0;
        if (|(rd_use & rd_pend)) begin
            stall = 1'b1;
        end else if (iss_en && ep_s[iss_addr]) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

endmodule
